// File: rtl/decoder_pkg.sv
// Shared decoder definitions: RV32 base opcode constants, the immediate
// format enum, the decoded-field record stored per queue entry, and small
// lookup helpers used by the queue and the immediate generator.
package decoder_pkg;

  localparam logic [6:0] OPC_LOAD     = 7'h03;
  localparam logic [6:0] OPC_MISC_MEM = 7'h0F;
  localparam logic [6:0] OPC_OP_IMM   = 7'h13;
  localparam logic [6:0] OPC_AUIPC    = 7'h17;
  localparam logic [6:0] OPC_STORE    = 7'h23;
  localparam logic [6:0] OPC_OP       = 7'h33;
  localparam logic [6:0] OPC_LUI      = 7'h37;
  localparam logic [6:0] OPC_BRANCH   = 7'h63;
  localparam logic [6:0] OPC_JALR     = 7'h67;
  localparam logic [6:0] OPC_JAL      = 7'h6F;
  localparam logic [6:0] OPC_SYSTEM   = 7'h73;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_format_e;

  // Everything the consumer needs from one instruction, minus the PC
  // (whose width is a per-instance parameter).
  typedef struct packed {
    logic [6:0]  opcode;
    logic [2:0]  function_3;
    logic [6:0]  function_7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] immediate;
  } decoded_t;

  // Which immediate layout an opcode uses; R-type and unknowns carry none.
  function automatic imm_format_e imm_format_of(input logic [6:0] opcode);
    imm_format_e fmt;
    case (opcode)
      OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_SYSTEM: fmt = IMM_I;
      OPC_STORE:                                  fmt = IMM_S;
      OPC_BRANCH:                                 fmt = IMM_B;
      OPC_LUI, OPC_AUIPC:                         fmt = IMM_U;
      OPC_JAL:                                    fmt = IMM_J;
      default:                                    fmt = IMM_NONE;
    endcase
    return fmt;
  endfunction

  // True for the eleven base-ISA major opcodes this decoder recognises.
  function automatic logic opcode_is_known(input logic [6:0] opcode);
    logic known;
    case (opcode)
      OPC_LOAD, OPC_MISC_MEM, OPC_OP_IMM, OPC_AUIPC, OPC_STORE, OPC_OP,
      OPC_LUI, OPC_BRANCH, OPC_JALR, OPC_JAL, OPC_SYSTEM: known = 1'b1;
      default:                                           known = 1'b0;
    endcase
    return known;
  endfunction

endpackage

// File: rtl/immediate_generator.sv
// Combinational RV32 immediate extraction: picks the layout from the opcode
// and returns the sign-extended 32-bit immediate (zero for formats without one).
module immediate_generator
  import decoder_pkg::*;
(
  input  logic [31:0] instruction,
  output logic [31:0] immediate
);

  imm_format_e fmt;

  assign fmt = imm_format_of(instruction[6:0]);

  // Reassemble the scattered immediate bits for the selected format.
  always_comb begin
    immediate = 32'd0;
    case (fmt)
      IMM_I: immediate = {{20{instruction[31]}}, instruction[31:20]};
      IMM_S: immediate = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
      IMM_B: immediate = {{19{instruction[31]}}, instruction[31], instruction[7],
                          instruction[30:25], instruction[11:8], 1'b0};
      IMM_U: immediate = {instruction[31:12], 12'd0};
      IMM_J: immediate = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                          instruction[20], instruction[30:21], 1'b0};
      default: immediate = 32'd0;
    endcase
  end

endmodule

// File: rtl/instruction_decode_queue.sv
// Instruction decode queue: decodes each fetched instruction as it is pushed
// and holds the decoded entries in a DEPTH-deep circular buffer. All out_*
// signals come from stored state only.
// Optional build macro: DECODE_ILLEGAL_CHECK_EN adds a per-entry illegal flag;
// without it out_illegal is tied low and no flag storage exists.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. in_ready (= !full) and out_valid (= !empty) depend only on the queue
// state, never on the same-cycle in_valid/out_ready, so a full queue refuses
// a push even while the head is being popped. While out_valid is high and
// out_ready is low the head entry and all out_* stay unchanged. flush and rst
// drop every entry and cancel any same-cycle push or pop.
module instruction_decode_queue
  import decoder_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int PC_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [31:0]               in_instruction,
  input  logic [PC_WIDTH-1:0]       in_pc,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [6:0]                out_opcode,
  output logic [2:0]                out_function_3,
  output logic [6:0]                out_function_7,
  output logic [4:0]                out_rd,
  output logic [4:0]                out_rs1,
  output logic [4:0]                out_rs2,
  output logic [31:0]               out_immediate,
  output logic [PC_WIDTH-1:0]       out_pc,
  output logic                      out_illegal,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  decoded_t            mem_fields [DEPTH];
  logic [PC_WIDTH-1:0] mem_pc     [DEPTH];
  logic [PW-1:0]       wptr;
  logic [PW-1:0]       rptr;
  logic [31:0]         in_immediate;
  decoded_t            in_decoded;
  decoded_t            head;
  logic                push;
  logic                pop;

  immediate_generator u_immediate_generator (
    .instruction (in_instruction),
    .immediate   (in_immediate)
  );

  assign in_ready  = (count != FULL_COUNT);
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Slice the fixed RV32 fields out of the incoming word.
  always_comb begin
    in_decoded            = '0;
    in_decoded.opcode     = in_instruction[6:0];
    in_decoded.rd         = in_instruction[11:7];
    in_decoded.function_3 = in_instruction[14:12];
    in_decoded.rs1        = in_instruction[19:15];
    in_decoded.rs2        = in_instruction[24:20];
    in_decoded.function_7 = in_instruction[31:25];
    in_decoded.immediate  = in_immediate;
  end

  // Pointer and occupancy update; rst beats flush, flush beats push/pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage: written only on an accepted push that is not cancelled.
  always_ff @(posedge clk) begin
    if (push && !rst && !flush) begin
      mem_fields[wptr] <= in_decoded;
      mem_pc[wptr]     <= in_pc;
    end
  end

  // Present the head entry; an empty queue shows all-zero data.
  always_comb begin
    head = '0;
    if (out_valid) head = mem_fields[rptr];
  end

  assign out_opcode     = head.opcode;
  assign out_function_3 = head.function_3;
  assign out_function_7 = head.function_7;
  assign out_rd         = head.rd;
  assign out_rs1        = head.rs1;
  assign out_rs2        = head.rs2;
  assign out_immediate  = head.immediate;
  assign out_pc         = out_valid ? mem_pc[rptr] : '0;

`ifdef DECODE_ILLEGAL_CHECK_EN
  logic mem_illegal [DEPTH];
  logic in_illegal;

  assign in_illegal = (in_instruction[1:0] != 2'b11) || !opcode_is_known(in_instruction[6:0]);

  // Illegal flag travels with its entry.
  always_ff @(posedge clk) begin
    if (push && !rst && !flush) mem_illegal[wptr] <= in_illegal;
  end

  assign out_illegal = out_valid && mem_illegal[rptr];
`else
  assign out_illegal = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_decode_queue.sv
// Self-checking bench for instruction_decode_queue (DEPTH=4, PC_WIDTH=32).
// A scoreboard queue of expected head entries is filled when a push is driven
// and drained when the DUT hands an entry to the consumer.
module tb_instruction_decode_queue;

  localparam int DEPTH    = 4;
  localparam int PC_WIDTH = 32;
  localparam int CW       = $clog2(DEPTH) + 1;
  localparam int W        = 7 + 3 + 7 + 5 + 5 + 5 + 32 + PC_WIDTH + 1;

  logic                clk;
  logic                rst;
  logic                flush;
  logic                in_valid;
  logic                in_ready;
  logic [31:0]         in_instruction;
  logic [PC_WIDTH-1:0] in_pc;
  logic                out_valid;
  logic                out_ready;
  logic [6:0]          out_opcode;
  logic [2:0]          out_function_3;
  logic [6:0]          out_function_7;
  logic [4:0]          out_rd;
  logic [4:0]          out_rs1;
  logic [4:0]          out_rs2;
  logic [31:0]         out_immediate;
  logic [PC_WIDTH-1:0] out_pc;
  logic                out_illegal;
  logic [CW-1:0]       count;

  logic [W-1:0] exp_q[$];
  int           n_cmp;
  int           n_err;
  logic         mon_en;

  instruction_decode_queue #(.DEPTH(DEPTH), .PC_WIDTH(PC_WIDTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_instruction (in_instruction),
    .in_pc          (in_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_opcode     (out_opcode),
    .out_function_3 (out_function_3),
    .out_function_7 (out_function_7),
    .out_rd         (out_rd),
    .out_rs1        (out_rs1),
    .out_rs2        (out_rs2),
    .out_immediate  (out_immediate),
    .out_pc         (out_pc),
    .out_illegal    (out_illegal),
    .count          (count)
  );

  // Clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference decode of one instruction into the packed head layout.
  function automatic logic [W-1:0] model(input logic [31:0] i, input logic [PC_WIDTH-1:0] pc);
    logic [31:0] imm;
    logic        ill;
    case (i[6:0])
      7'h03, 7'h13, 7'h67, 7'h73: imm = {{20{i[31]}}, i[31:20]};
      7'h23: imm = {{20{i[31]}}, i[31:25], i[11:7]};
      7'h63: imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      7'h37, 7'h17: imm = {i[31:12], 12'd0};
      7'h6F: imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default: imm = 32'd0;
    endcase
`ifdef DECODE_ILLEGAL_CHECK_EN
    case (i[6:0])
      7'h03, 7'h0F, 7'h13, 7'h17, 7'h23, 7'h33,
      7'h37, 7'h63, 7'h67, 7'h6F, 7'h73: ill = (i[1:0] != 2'b11);
      default: ill = 1'b1;
    endcase
`else
    ill = 1'b0;
`endif
    return {i[6:0], i[14:12], i[31:25], i[11:7], i[19:15], i[24:20], imm, pc, ill};
  endfunction

  // One clock: at the falling edge check status and run the scoreboard for
  // the inputs about to be sampled, then return just after the rising edge.
  task automatic tick();
    logic [W-1:0] act;
    logic [W-1:0] exp;
    logic         was_full;
    @(negedge clk);
    if (mon_en) begin
      n_cmp++;
      if (count !== CW'(exp_q.size()) || out_valid !== (exp_q.size() != 0) ||
          in_ready !== (exp_q.size() != DEPTH)) begin
        n_err++;
        $display("FAIL status: count=%0d out_valid=%b in_ready=%b, required count=%0d out_valid=%b in_ready=%b",
                 count, out_valid, in_ready, exp_q.size(), exp_q.size() != 0, exp_q.size() != DEPTH);
      end
    end
    if (rst || flush) begin
      exp_q.delete();
    end else begin
      was_full = (exp_q.size() == DEPTH);
      if (out_ready && exp_q.size() != 0) begin
        exp = exp_q.pop_front();
        act = {out_opcode, out_function_3, out_function_7, out_rd, out_rs1, out_rs2,
               out_immediate, out_pc, out_illegal};
        if (mon_en) begin
          n_cmp++;
          if (act !== exp) begin
            n_err++;
            $display("FAIL pop_entry: got %h, required %h", act, exp);
          end
        end
      end
      if (in_valid && !was_full) exp_q.push_back(model(in_instruction, in_pc));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    in_valid       = 1'b0;
    in_instruction = 32'd0;
    in_pc          = '0;
    out_ready      = 1'b0;
    flush          = 1'b0;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 4 * DEPTH && exp_q.size() != 0; k++) tick();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain_timeout: %0d entries left, required 0", exp_q.size());
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    mon_en = 1'b0;
    drive_idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    n_cmp++;
    if (count !== '0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_status: count=%0d in_ready=%b out_valid=%b, required 0 1 0", count, in_ready, out_valid);
    end
    n_cmp++;
    if (out_opcode !== 7'd0 || out_immediate !== 32'd0 || out_pc !== '0 || out_illegal !== 1'b0) begin
      n_err++;
      $display("FAIL reset_data: opcode=%h imm=%h pc=%h ill=%b, required zeros",
               out_opcode, out_immediate, out_pc, out_illegal);
    end
    mon_en = 1'b1;
  endtask

  task automatic test_decode();
    logic [31:0] ins   [4] = '{32'h00510093, 32'h00512423, 32'hFE000EE3, 32'h123450B7};
    logic [6:0]  e_opc [4] = '{7'h13, 7'h23, 7'h63, 7'h37};
    logic [4:0]  e_rd  [4] = '{5'd1, 5'd8, 5'd29, 5'd1};
    logic [4:0]  e_rs1 [4] = '{5'd2, 5'd2, 5'd0, 5'd8};
    logic [4:0]  e_rs2 [4] = '{5'd5, 5'd5, 5'd0, 5'd3};
    logic [2:0]  e_f3  [4] = '{3'd0, 3'd2, 3'd0, 3'd5};
    logic [6:0]  e_f7  [4] = '{7'h00, 7'h00, 7'h7F, 7'h09};
    logic [31:0] e_imm [4] = '{32'd5, 32'd8, 32'hFFFFFFFC, 32'h12345000};
    for (int t = 0; t < 4; t++) begin
      out_ready      = 1'b0;
      in_valid       = 1'b1;
      in_instruction = ins[t];
      in_pc          = 32'h100 + 32'(4 * t);
      tick();
      in_valid = 1'b0;
      n_cmp++;
      if (out_valid !== 1'b1 || out_opcode !== e_opc[t] || out_rd !== e_rd[t] ||
          out_rs1 !== e_rs1[t] || out_rs2 !== e_rs2[t] || out_function_3 !== e_f3[t] ||
          out_function_7 !== e_f7[t]) begin
        n_err++;
        $display("FAIL decode_fields[%0d]: v=%b opc=%h rd=%0d rs1=%0d rs2=%0d f3=%0d f7=%h, required 1 %h %0d %0d %0d %0d %h",
                 t, out_valid, out_opcode, out_rd, out_rs1, out_rs2, out_function_3, out_function_7,
                 e_opc[t], e_rd[t], e_rs1[t], e_rs2[t], e_f3[t], e_f7[t]);
      end
      n_cmp++;
      if (out_immediate !== e_imm[t] || out_pc !== 32'h100 + 32'(4 * t)) begin
        n_err++;
        $display("FAIL decode_imm_pc[%0d]: imm=%h pc=%h, required %h %h",
                 t, out_immediate, out_pc, e_imm[t], 32'h100 + 32'(4 * t));
      end
      tick();  // head held with out_ready low
      n_cmp++;
      if (out_immediate !== e_imm[t] || out_valid !== 1'b1) begin
        n_err++;
        $display("FAIL hold_stable[%0d]: imm=%h v=%b, required %h 1", t, out_immediate, out_valid, e_imm[t]);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
  endtask

  task automatic test_full();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin
      in_instruction = 32'h00000093 | (32'(k + 1) << 20);
      in_pc          = 32'h200 + 32'(4 * k);
      tick();
    end
    n_cmp++;
    if (count !== CW'(DEPTH) || in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL full_after_4: count=%0d in_ready=%b, required 4 0", count, in_ready);
    end
    in_instruction = 32'h00500093;
    in_pc          = 32'h210;
    tick();
    n_cmp++;
    if (count !== CW'(DEPTH)) begin
      n_err++;
      $display("FAIL fifth_rejected: count=%0d, required 4", count);
    end
    out_ready = 1'b1;
    tick();  // pop while full: push still refused
    n_cmp++;
    if (count !== CW'(DEPTH - 1)) begin
      n_err++;
      $display("FAIL full_pop_no_push: count=%0d, required 3", count);
    end
    in_valid = 1'b0;
    for (int k = DEPTH - 2; k >= 0; k--) begin
      tick();
      n_cmp++;
      if (count !== CW'(k)) begin
        n_err++;
        $display("FAIL drain_count: count=%0d, required %0d", count, k);
      end
    end
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int k = 0; k < 2; k++) begin
      in_instruction = 32'h00000013 | (32'(k) << 7);
      in_pc          = 32'h300 + 32'(4 * k);
      tick();
    end
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      in_instruction = {$urandom_range(0, 32'h01FFFFFF), 7'h13};
      in_pc          = 32'h400 + 32'(4 * k);
      tick();
      n_cmp++;
      if (count !== CW'(2)) begin
        n_err++;
        $display("FAIL push_pop_count[%0d]: count=%0d, required 2", k, count);
      end
    end
    drain();
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_instruction = 32'h00002003 | (32'(k) << 20);
      in_pc          = 32'h500 + 32'(4 * k);
      tick();
    end
    flush = 1'b1;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    n_cmp++;
    if (count !== '0 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL flush_empty: count=%0d out_valid=%b, required 0 0", count, out_valid);
    end
    in_valid       = 1'b1;
    in_instruction = 32'h0040006F;
    in_pc          = 32'h600;
    tick();
    in_valid = 1'b0;
    n_cmp++;
    if (out_immediate !== 32'd4 || out_pc !== 32'h600) begin
      n_err++;
      $display("FAIL after_flush_jal: imm=%h pc=%h, required 4 600", out_immediate, out_pc);
    end
    drain();
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_instruction = 32'h00000033 | (32'(k) << 15);
      in_pc          = 32'h700 + 32'(4 * k);
      tick();
    end
    rst       = 1'b1;
    flush     = 1'b1;
    out_ready = 1'b1;
    tick();
    rst       = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    n_cmp++;
    if (count !== '0 || out_valid !== 1'b0 || out_pc !== '0 || out_opcode !== 7'd0) begin
      n_err++;
      $display("FAIL midstream_reset: count=%0d v=%b pc=%h opc=%h, required 0 0 0 0",
               count, out_valid, out_pc, out_opcode);
    end
  endtask

  task automatic test_illegal();
    logic [31:0] ins   [2] = '{32'h0000007F, 32'h00000013};
    logic        e_ill [2];
`ifdef DECODE_ILLEGAL_CHECK_EN
    e_ill = '{1'b1, 1'b0};
`else
    e_ill = '{1'b0, 1'b0};
`endif
    for (int t = 0; t < 2; t++) begin
      out_ready      = 1'b0;
      in_valid       = 1'b1;
      in_instruction = ins[t];
      in_pc          = 32'h800 + 32'(4 * t);
      tick();
      in_valid = 1'b0;
      n_cmp++;
      if (out_illegal !== e_ill[t]) begin
        n_err++;
        $display("FAIL illegal_flag[%0d]: got %b, required %b", t, out_illegal, e_ill[t]);
      end
      out_ready = 1'b1;
      tick();
    end
    out_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [31:0] r;
    logic [6:0]  opc;
    for (int k = 0; k < 300; k++) begin
      r = $urandom();
      case ($urandom_range(0, 11))
        0: opc = 7'h03;  1: opc = 7'h13;  2: opc = 7'h23;  3: opc = 7'h63;
        4: opc = 7'h37;  5: opc = 7'h17;  6: opc = 7'h6F;  7: opc = 7'h67;
        8: opc = 7'h33;  9: opc = 7'h73; 10: opc = 7'h0F; default: opc = r[6:0];
      endcase
      in_instruction = {r[31:7], opc};
      in_pc          = $urandom();
      in_valid       = ($urandom_range(0, 2) != 0);
      out_ready      = ($urandom_range(0, 2) != 0);
      flush          = ($urandom_range(0, 59) == 0);
      tick();
    end
    flush = 1'b0;
    drain();
  endtask

  initial begin
    n_cmp  = 0;
    n_err  = 0;
    mon_en = 1'b0;
    rst    = 1'b1;
    drive_idle();
    test_reset();
    test_decode();
    test_full();
    test_back_to_back();
    test_flush();
    test_reset_midstream();
    test_illegal();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/instruction_decode_queue.md
INSTRUCTION_DECODE_QUEUE -- requirements
Module: instruction_decode_queue

Interface
- REQ-001 SHALL have parameter DEPTH, default 4: queue entries; power of two, 2..16.
- REQ-002 SHALL have parameter PC_WIDTH, default 32: width of the carried program counter.
- REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
- REQ-004 SHALL have port rst, input, 1: synchronous active-high reset.
- REQ-005 SHALL have port flush, input, 1: discard all queued entries.
- REQ-006 SHALL have port in_valid, input, 1: fetch presents an instruction.
- REQ-007 SHALL have port in_ready, output, 1: queue accepts (= !full).
- REQ-008 SHALL have port in_instruction, input, 32: raw instruction word.
- REQ-009 SHALL have port in_pc, input, PC_WIDTH: instruction address.
- REQ-010 SHALL have port out_valid, output, 1: head entry valid (= !empty).
- REQ-011 SHALL have port out_ready, input, 1: consumer takes head.
- REQ-012 SHALL have ports out_opcode 7, out_function_3 3, out_function_7 7, out_rd 5, out_rs1 5, out_rs2 5, all outputs: fields of head entry.
- REQ-013 SHALL have port out_immediate, output, 32: sign-extended immediate of head entry.
- REQ-014 SHALL have port out_pc, output, PC_WIDTH: head entry PC.
- REQ-015 SHALL have port out_illegal, output, 1: head entry flagged illegal.
- REQ-016 SHALL have port count, output, $clog2(DEPTH)+1: occupied entries.

Function
- REQ-017 SHALL push when in_valid && in_ready, pop when out_valid && out_ready.
- REQ-018 SHALL decode at push time and store decoded fields, immediate, PC, illegal flag in the entry; outputs SHALL be driven from registered head entry only (no combinational path from in_* to out_*).
- REQ-019 SHALL have latency one cycle: entry pushed in cycle N is visible at out_* in cycle N+1 if queue was empty.
- REQ-020 SHALL field-slice: opcode [6:0], rd [11:7], function_3 [14:12], rs1 [19:15], rs2 [24:20], function_7 [31:25].
- REQ-021 SHALL generate immediate by opcode: I (0x03,0x13,0x67,0x73), S (0x23), B (0x63), U (0x37,0x17), J (0x6F); all others (incl. R 0x33) give 0.
- REQ-022 SHALL allow simultaneous push and pop when neither full nor empty; count unchanged.
- REQ-023 SHALL not push when full, even if out_ready same cycle (in_ready depends on state only).
- REQ-024 SHALL wrap read/write pointers modulo DEPTH.
- REQ-025 SHALL on flush empty the queue next cycle and ignore any same-cycle push/pop; flush has priority over push.
- REQ-026 SHALL hold out_* stable while out_valid && !out_ready.

Reset
- REQ-027 SHALL on rst: pointers 0, count 0, in_ready 1, out_valid 0; out_* data fields 0; rst has priority over flush, push, pop.
- REQ-028 SHALL on rst mid-stream drop all entries with no partial pop.

Configuration
- REQ-029 SHALL with DECODE_ILLEGAL_CHECK_EN defined set out_illegal when instruction[1:0] != 2'b11 or opcode not among 0x03,0x0F,0x13,0x17,0x23,0x33,0x37,0x63,0x67,0x6F,0x73.
- REQ-030 SHALL without DECODE_ILLEGAL_CHECK_EN tie out_illegal to 0 and store no illegal bit.

Structure
- REQ-031 SHALL take opcode constants and immediate-format enum from shared package decoder_pkg.
- REQ-032 SHALL place immediate generation in sub-module immediate_generator (32-bit instruction in, 32-bit immediate out, combinational).

Verification
- REQ-033 push 0x00510093 (addi x1,x2,5), pc 0x100 -> next cycle out_valid 1, opcode 0x13, rd 1, rs1 2, function_3 0, immediate 5, out_pc 0x100.
- REQ-034 push 0x00512423 (sw x5,8(x2)) -> rs1 2, rs2 5, function_3 2, immediate 8; push 0xFE000EE3 (beq -4) -> immediate 0xFFFFFFFC; push 0x123450B7 (lui) -> immediate 0x12345000.
- REQ-035 DEPTH=4, out_ready 0, push 5 words -> count 4, in_ready 0 after 4th, 5th not accepted; raise out_ready -> in FIFO order, count decrements.
- REQ-036 count 2, push and pop same cycle -> count stays 2; ordering preserved across pointer wrap over 10 entries.
- REQ-037 count 3, flush with in_valid 1 -> next cycle count 0, out_valid 0; rst mid-stream -> same.
- REQ-038 with DECODE_ILLEGAL_CHECK_EN, push 0x0000007F -> out_illegal 1; push 0x00000013 -> 0; without macro both -> 0.
